// File: rtl/tt_um_sahrdaya_lfsr_pkg.sv
// Shared constants for the Sahrdaya LFSR tile: register widths, tap mask,
// reset seed, prescaler geometry and the hex seven-segment table.
package tt_um_sahrdaya_lfsr_pkg;

  localparam int unsigned LFSR_W     = 8;
  localparam int unsigned PRESCALE_W = 21;

  // Taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form: bits 7,5,4,3.
  localparam logic [LFSR_W-1:0] TAP_MASK   = 8'hB8;
  localparam logic [LFSR_W-1:0] RESET_SEED = 8'h01;

  // Segment patterns, a = bit0 .. g = bit6, active high; index 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

  // Low 3*P bits of the prescale counter that must all be ones for a tick.
  // P = 0 yields an empty mask, so the tick condition is always true.
  function automatic logic [PRESCALE_W-1:0] prescale_mask(input logic [2:0] p);
    logic [PRESCALE_W-1:0] m;
    case (p)
      3'd0:    m = '0;
      3'd1:    m = 21'h000007;
      3'd2:    m = 21'h00003F;
      3'd3:    m = 21'h0001FF;
      3'd4:    m = 21'h000FFF;
      3'd5:    m = 21'h007FFF;
      3'd6:    m = 21'h03FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tt_um_sahrdaya_lfsr_seg7_hex.sv
// Combinational hex-digit to seven-segment decoder (active-high segments).
module seg7_hex
  import tt_um_sahrdaya_lfsr_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Pure table lookup of the nibble's glyph.
  always_comb begin
    o_seg = SEG_TABLE[i_hex];
  end

endmodule

// File: rtl/tt_um_sahrdaya_lfsr.sv
// 8-bit Fibonacci LFSR with prescaled free-run, single-step, seed load and
// a hex nibble shown on a seven-segment display.
module tt_um_sahrdaya_lfsr
  import tt_um_sahrdaya_lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [LFSR_W-1:0]     r_lfsr;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_step_prev;

  logic                  w_run;
  logic                  w_load;
  logic                  w_digit_hi;
  logic [2:0]            w_psel;
  logic                  w_step_in;
  logic [PRESCALE_W-1:0] w_mask;
  logic                  w_tick;
  logic                  w_step_pulse;
  logic                  w_fb;
  logic [LFSR_W-1:0]     w_next;
  logic [LFSR_W-1:0]     w_seed;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;

  // Decode controls, tick, step edge, next LFSR value and load seed.
  always_comb begin
    w_run        = ui_in[0];
    w_load       = ui_in[1];
    w_digit_hi   = ui_in[2];
    w_psel       = ui_in[5:3];
    w_step_in    = ui_in[6];
    w_mask       = prescale_mask(w_psel);
    w_tick       = ((r_cnt & w_mask) == w_mask);
    w_step_pulse = w_step_in & ~r_step_prev;
    w_fb         = ^(r_lfsr & TAP_MASK);
    w_next       = {r_lfsr[LFSR_W-2:0], w_fb};
    // An all-zero seed would lock the LFSR, so substitute the reset seed.
    w_seed       = (uio_in == '0) ? RESET_SEED : uio_in;
    w_nibble     = w_digit_hi ? r_lfsr[7:4] : r_lfsr[3:0];
  end

  // State update: reset beats ena; then load > run-tick > manual step > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr      <= RESET_SEED;
      r_cnt       <= '0;
      r_step_prev <= 1'b0;
    end else if (ena) begin
      r_step_prev <= w_step_in;
      if (w_load) begin
        r_lfsr <= w_seed;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + PRESCALE_W'(1);
        if ((w_run && w_tick) || (!w_run && w_step_pulse)) begin
          r_lfsr <= w_next;
        end
      end
    end
  end

  seg7_hex u_seg7_hex (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  // Outputs follow the state register directly; no extra pipeline stage.
  always_comb begin
    uo_out  = {r_lfsr[7], w_seg};
    uio_out = r_lfsr;
    uio_oe  = ui_in[7] ? 8'h00 : 8'hFF;
  end

endmodule

// File: tb/tb_tt_um_sahrdaya_lfsr.sv
// Self-checking bench for tt_um_sahrdaya_lfsr: per-cycle scoreboard against a
// behavioural model plus directed checks of the documented sequences.
module tb_tt_um_sahrdaya_lfsr;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] uo;
    logic [7:0] oe;
  } exp_t;

  exp_t q[$];

  // Behavioural model state
  logic [7:0]  m_s;
  int unsigned m_c;
  logic        m_prev;

  tt_um_sahrdaya_lfsr dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge, queue the expected outputs, clock the DUT,
  // then pop and compare.
  task automatic cyc();
    exp_t        e;
    exp_t        got;
    int unsigned p;
    int unsigned mask;
    logic        tick;
    logic        fb;
    p = int'(ui_in[5:3]);
    if (!rst_n) begin
      m_s = 8'h01; m_c = 0; m_prev = 1'b0;
    end else if (ena) begin
      mask = (32'd1 << (3 * p)) - 1;
      tick = ((m_c & mask) == mask);
      fb   = m_s[7] ^ m_s[5] ^ m_s[4] ^ m_s[3];
      if (ui_in[1]) begin
        m_s = (uio_in == 8'h00) ? 8'h01 : uio_in;
        m_c = 0;
      end else begin
        m_c = (m_c + 1) & 32'h001F_FFFF;
        if ((ui_in[0] && tick) || (!ui_in[0] && ui_in[6] && !m_prev))
          m_s = {m_s[6:0], fb};
      end
      m_prev = ui_in[6];
    end
    e.s  = m_s;
    e.uo = {m_s[7], seg_of(ui_in[2] ? m_s[7:4] : m_s[3:0])};
    e.oe = ui_in[7] ? 8'h00 : 8'hFF;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("sb_uio_out", uio_out, got.s);
    chk("sb_uo_out",  uo_out,  got.uo);
    chk("sb_uio_oe",  uio_oe,  got.oe);
  endtask

  initial begin
    logic [7:0] seq6 [6];
    logic       seen [256];
    seq6 = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    m_s = 8'h00; m_c = 0; m_prev = 1'b0;

    // Reset
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    cyc(); cyc();
    chk("reset_uo_out",  uo_out,  8'h06);
    chk("reset_uio_out", uio_out, 8'h01);
    chk("reset_uio_oe",  uio_oe,  8'hFF);

    // Free-run at P = 0: documented sequence, then full period
    rst_n = 1'b1; ui_in = 8'h01;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      cyc();
      if (k <= 6) chk("run_seq", uio_out, seq6[k-1]);
      if (k < 255) begin
        chk("period_norepeat", {7'b0, seen[uio_out]}, 8'h00);
        seen[uio_out] = 1'b1;
      end else begin
        chk("period_return", uio_out, 8'h01);
      end
    end

    // Load: zero seed substitution, A5 on high digit, held load, ui_in[7]
    ui_in = 8'h02; uio_in = 8'h00;
    cyc();
    chk("load_zero", uio_out, 8'h01);
    ui_in = 8'h06; uio_in = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("load_a5_held", uio_out, 8'hA5);
    end
    chk("load_a5_seg", uo_out, 8'hF7);
    ui_in = 8'h86; uio_in = 8'h3C;
    cyc();
    chk("load_dir_in", uio_out, 8'h3C);
    chk("oe_dir_in",   uio_oe,  8'h00);

    // Manual step: one step for a held-high step input
    ui_in = 8'h00;
    cyc();
    ui_in = 8'h40;
    for (int k = 0; k < 5; k++) cyc();
    chk("step_once", uio_out, 8'h79);
    ui_in = 8'h00;
    cyc();
    // run = 1 with P = 7: step edge ignored, no tick yet
    ui_in = 8'h39;
    cyc();
    ui_in = 8'h79;
    for (int k = 0; k < 3; k++) cyc();
    chk("step_ignored_run", uio_out, 8'h79);

    // P = 1 after reset: step every 8 cycles; ena = 0 freezes S and C
    rst_n = 1'b0; ui_in = 8'h00;
    cyc();
    rst_n = 1'b1; ui_in = 8'h09;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (k == 7)  chk("p1_c7",  uio_out, 8'h01);
      if (k == 8)  chk("p1_c8",  uio_out, 8'h02);
      if (k == 15) chk("p1_c15", uio_out, 8'h02);
      if (k == 16) chk("p1_c16", uio_out, 8'h04);
      if (k == 24) chk("p1_c24", uio_out, 8'h08);
    end
    ena = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("ena_freeze", uio_out, 8'h08);
    ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 7) chk("ena_resume_c7", uio_out, 8'h08);
      if (k == 8) chk("ena_resume_c8", uio_out, 8'h11);
    end

    // Mid-run reset, also with ena low and load requested
    ui_in = 8'h01;
    for (int k = 0; k < 5; k++) cyc();
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h03; uio_in = 8'h5A;
    cyc();
    chk("midrun_reset", uio_out, 8'h01);
    chk("midrun_reset_seg", uo_out, 8'h06);
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
